happy_bday: RTL and testbench



---
 rtl/happy_bday_pkg.sv | 41 ++++
 rtl/happy_bday_tone_gen.sv | 30 +++
 rtl/happy_bday.sv | 46 ++++
 tb/tb_happy_bday.sv | 100 ++++++++++
 4 files changed

// File: rtl/happy_bday_pkg.sv
// happy_bday_pkg: note set, 12 MHz half-period constants and the birthday score ROM
package happy_bday_pkg;
  localparam int HALF_W = 14;
  localparam int SCORE_LEN = 27;
  typedef enum logic [3:0] {REST, G4, A4, B4, C5, D5, E5, F5, G5} note_t;
  localparam logic [HALF_W-1:0] HALF_G4 = 14'd15306;
  localparam logic [HALF_W-1:0] HALF_A4 = 14'd13636;
  localparam logic [HALF_W-1:0] HALF_B4 = 14'd12149;
  localparam logic [HALF_W-1:0] HALF_C5 = 14'd11467;
  localparam logic [HALF_W-1:0] HALF_D5 = 14'd10216;
  localparam logic [HALF_W-1:0] HALF_E5 = 14'd9101;
  localparam logic [HALF_W-1:0] HALF_F5 = 14'd8590;
  localparam logic [HALF_W-1:0] HALF_G5 = 14'd7653;
  // Slots 25 and 26 fall through to REST, giving the pause before the loop restarts
  function automatic note_t score(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd1, 5'd3, 5'd6, 5'd7, 5'd9, 5'd12, 5'd13: score = G4;
      5'd2, 5'd8, 5'd18:                                score = A4;
      5'd5, 5'd17:                                      score = B4;
      5'd4, 5'd11, 5'd16, 5'd22, 5'd24:                 score = C5;
      5'd10, 5'd23:                                     score = D5;
      5'd15, 5'd21:                                     score = E5;
      5'd19, 5'd20:                                     score = F5;
      5'd14:                                            score = G5;
      default:                                          score = REST;
    endcase
  endfunction
  function automatic logic [HALF_W-1:0] half_period(input note_t n);
    case (n)
      G4:      half_period = HALF_G4;
      A4:      half_period = HALF_A4;
      B4:      half_period = HALF_B4;
      C5:      half_period = HALF_C5;
      D5:      half_period = HALF_D5;
      E5:      half_period = HALF_E5;
      F5:      half_period = HALF_F5;
      G5:      half_period = HALF_G5;
      default: half_period = '0;
    endcase
  endfunction
endpackage

// File: rtl/happy_bday_tone_gen.sv
// tone_gen: 50% duty square wave toggling every `half` clocks, held low when idle
module tone_gen
  import happy_bday_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [HALF_W-1:0] half,
  input  logic              en,
  input  logic              restart,
  output logic              wave
);
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic wave_q, wave_d, hold, expire;
  always_comb begin
    hold = restart || !en;
    expire = cnt_q == half - 14'd1;
    cnt_d = hold || expire ? '0 : cnt_q + 14'd1;
    wave_d = hold ? 1'b0 : wave_q ^ expire;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wave_q <= wave_d;
    end
  end
  assign wave = wave_q;
endmodule

// File: rtl/happy_bday.sv
// happy_bday: self-running music box sequencing the birthday score onto a speaker pin
module happy_bday
  import happy_bday_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int NOTE_CYCLES = 6_000_000,
  parameter int GAP_CYCLES  = 375_000
) (
  input  logic clk,
  input  logic rst,
  output logic speaker
);
  localparam int DW = $clog2(NOTE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(NOTE_CYCLES - 1);
  localparam logic [DW-1:0] GAP_START = DW'(NOTE_CYCLES - GAP_CYCLES);
  localparam bit CFG_OK = CLK_HZ > 0 && GAP_CYCLES < NOTE_CYCLES;
  logic [DW-1:0] dur_q, dur_d;
  logic [4:0] idx_q, idx_d;
  logic [HALF_W-1:0] half;
  logic wrap, en;
  // Gap is judged on the next slot position so the speaker is low for exactly GAP_CYCLES clocks
  always_comb begin
    wrap = dur_q == LAST;
    dur_d = wrap ? '0 : dur_q + 1'b1;
    idx_d = !wrap ? idx_q : idx_q == 5'(SCORE_LEN - 1) ? '0 : idx_q + 5'd1;
    half = half_period(score(idx_q));
    en = CFG_OK && half != '0 && dur_d < GAP_START;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_q <= '0;
      idx_q <= '0;
    end else begin
      dur_q <= dur_d;
      idx_q <= idx_d;
    end
  end
  tone_gen u_tone (
    .clk    (clk),
    .rst    (rst),
    .half   (half),
    .en     (en),
    .restart(wrap),
    .wave   (speaker)
  );
endmodule

// File: tb/tb_happy_bday.sv
// tb_happy_bday: fast-slot sequencing checks plus a speaker edge scoreboard with async reset
module tb_happy_bday;
  localparam int NA = 31000, GA = 1000, NB = 64, GB = 8;
  typedef struct { int cyc; logic val; } ev_t;
  logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  logic spk_a, spk_b, prev_a = 1'b0;
  int cyc_a = 0, cyc_b = 0, errors = 0, checks = 0;
  ev_t exp_q[$];
  int exp_half [27] = '{15306, 15306, 13636, 15306, 11467, 12149,
                        15306, 15306, 13636, 15306, 10216, 11467,
                        15306, 15306, 7653, 9101, 11467, 12149, 13636,
                        8590, 8590, 9101, 11467, 10216, 11467, 0, 0};
  happy_bday #(.NOTE_CYCLES(NA), .GAP_CYCLES(GA)) u_a (.clk(clk), .rst(rst_a), .speaker(spk_a));
  happy_bday #(.NOTE_CYCLES(NB), .GAP_CYCLES(GB)) u_b (.clk(clk), .rst(rst_b), .speaker(spk_b));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst_a) cyc_a <= rst_a ? 0 : cyc_a + 1;
  always @(posedge clk or posedge rst_b) cyc_b <= rst_b ? 0 : cyc_b + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask
  // Every speaker edge of u_a is matched against the next scoreboard entry
  task automatic step_to(input int n);
    ev_t e;
    while (cyc_a < n) begin
      @(negedge clk);
      if (spk_a !== prev_a) begin
        prev_a = spk_a;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL spurious_edge: observed edge to %0d at cycle %0d expected none", spk_a, cyc_a);
        end else begin
          e = exp_q.pop_front();
          chk("edge_cycle", cyc_a, e.cyc);
          chk("edge_value", {31'd0, spk_a}, {31'd0, e.val});
        end
      end
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_spk_a", {31'd0, spk_a}, 0);
    chk("reset_spk_b", {31'd0, spk_b}, 0);
    chk("reset_idx_b", {27'd0, u_b.idx_q}, 0);
    #2 rst_b = 1'b0;
    for (int s = 0; s < 28; s++) begin
      while (cyc_b < s * NB + NB / 2) @(negedge clk);
      chk($sformatf("slot%0d_idx", s), {27'd0, u_b.idx_q}, s % 27);
      chk($sformatf("slot%0d_half", s), {18'd0, u_b.half}, exp_half[s % 27]);
      chk($sformatf("slot%0d_spk", s), {31'd0, spk_b}, 0);
    end
    @(negedge clk);
    #2 rst_a = 1'b0;
    exp_q.push_back(ev_t'{15306, 1'b1});
    step_to(16000);
    chk("g4_high", {31'd0, spk_a}, 1);
    @(negedge clk);
    #2 rst_a = 1'b1;
    #1 chk("async_rst_low", {31'd0, spk_a}, 0);
    #1 rst_a = 1'b0;
    prev_a = 1'b0;
    chk("first_events_done", exp_q.size(), 0);
    exp_q.push_back(ev_t'{15306, 1'b1});
    exp_q.push_back(ev_t'{30000, 1'b0});
    exp_q.push_back(ev_t'{46306, 1'b1});
    exp_q.push_back(ev_t'{61000, 1'b0});
    step_to(15305);
    chk("pre_rise_low", {31'd0, spk_a}, 0);
    step_to(15306);
    chk("rise_g4", {31'd0, spk_a}, 1);
    step_to(29999);
    chk("before_gap_high", {31'd0, spk_a}, 1);
    step_to(30000);
    chk("gap_low", {31'd0, spk_a}, 0);
    step_to(31000);
    chk("slot1_start_low", {31'd0, spk_a}, 0);
    step_to(46305);
    chk("slot1_pre_rise", {31'd0, spk_a}, 0);
    step_to(46306);
    chk("slot1_rise", {31'd0, spk_a}, 1);
    step_to(60999);
    chk("slot1_before_gap", {31'd0, spk_a}, 1);
    step_to(61000);
    chk("slot1_gap_low", {31'd0, spk_a}, 0);
    step_to(62050);
    chk("slot2_start_low", {31'd0, spk_a}, 0);
    chk("events_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
